spi_byte_rx: RTL

//   SPI slave front end (mode 0: CPOL=0, CPHA=0) that deserialises MOSI into bytes for the

---
 rtl/spi_byte_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave receiver: oversamples SCLK/MOSI/CS_N in the clk_i domain and emits one byte per 8 SCLK rises.
// Optional transmit path (spi_tx_data_i / spi_miso_o) is enabled by defining SPI_BYTE_RX_MISO_EN.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    input  logic       spi_cs_n_i,
    output logic       spi_busy_o,
    output logic       spi_byte_vld_o,
    output logic [7:0] spi_byte_data_o
`ifdef SPI_BYTE_RX_MISO_EN
    ,
    input  logic [7:0] spi_tx_data_i,
    output logic       spi_miso_o
`endif
);

    typedef enum logic {IDLE, ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_d_q;
    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d, shift_in;
    logic [7:0]             data_q, data_d;
    logic                   vld_q, vld_d;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, sclk_fall, byte_done;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d_q;
    assign sclk_fall = ~sclk_s & sclk_d_q;
    assign shift_in  = MSB_FIRST ? {shift_q[6:0], mosi_s} : {mosi_s, shift_q[7:1]};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_d_q    <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            vld_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            sclk_d_q    <= sclk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            vld_q       <= vld_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        byte_done = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                shift_d   = 8'h00;
                if (!cs_s) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (sclk_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        data_d    = shift_in;
                        vld_d     = 1'b1;
                        byte_done = 1'b1;
                    end
                end
                // A byte finishing in the same cycle CS rises still completes above.
                if (cs_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_busy_o      = (state_q == ACTIVE);
    assign spi_byte_vld_o  = vld_q;
    assign spi_byte_data_o = data_q;

`ifdef SPI_BYTE_RX_MISO_EN
    logic [7:0] tx_q, tx_d;

    always_comb begin
        tx_d = tx_q;
        if ((state_q == IDLE && !cs_s) || byte_done) begin
            tx_d = spi_tx_data_i;
        end else if (state_q == ACTIVE && sclk_fall && bit_cnt_q != 3'd0) begin
            // The fall after the 8th rise must not shift out the freshly loaded byte's first bit.
            tx_d = MSB_FIRST ? {tx_q[6:0], 1'b0} : {1'b0, tx_q[7:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) tx_q <= 8'h00;
        else          tx_q <= tx_d;
    end

    assign spi_miso_o = (state_q == ACTIVE) ? (MSB_FIRST ? tx_q[7] : tx_q[0]) : 1'b0;
`endif

endmodule
